// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first and keeps a
// saturating reference count of overlapping "101" occurrences in the stream.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LENW  = 4,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LENW-1:0]  len,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    hits
);

  // state_reg names what is visible on the outputs during the current cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sr_reg;
  logic [LENW-1:0]  cnt_reg;
  logic [1:0]       h_reg;

  logic [LENW-1:0]  len_clamp;
  logic [WIDTH-1:0] aligned;
  logic             bit_next;
  logic             hit_next;

  always_comb begin
    len_clamp = (len > WIDTH_L) ? WIDTH_L : len;
    // Left-align the active field so the next bit is always at the MSB
    aligned   = data << (WIDTH_L - len_clamp);
    bit_next  = sr_reg[WIDTH-1];
    hit_next  = (h_reg == 2'b10) && bit_next && (hits != {CW{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      h_reg     <= 2'b00;
      x         <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hits      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && (len != '0)) begin
            state_reg <= S_SEND;
            sr_reg    <= aligned << 1;
            cnt_reg   <= len_clamp - 1'b1;
            // History restarts with the first bit so patterns never span frames
            h_reg     <= {1'b0, aligned[WIDTH-1]};
            hits      <= '0;
            x         <= aligned[WIDTH-1];
            valid     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_SEND: begin
          if (cnt_reg == '0) begin
            state_reg <= S_DONE;
            x         <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            sr_reg  <= sr_reg << 1;
            x       <= bit_next;
            h_reg   <= {h_reg[0], bit_next};
            if (hit_next) begin
              hits <= hits + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          x         <= 1'b0;
          valid     <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; a second instance with CW=1 checks
// saturation of the hits counter on the same stimulus.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] len = '0;

  logic       x, valid, busy, done;
  logic [3:0] hits;
  logic       x_s, valid_s, busy_s, done_s;
  logic [0:0] hits_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .LENW(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .x(x), .valid(valid), .busy(busy), .done(done), .hits(hits)
  );

  seq_pattern_tx #(.WIDTH(8), .LENW(4), .CW(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .x(x_s), .valid(valid_s), .busy(busy_s), .done(done_s), .hits(hits_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [3:0] exp_hits);
    check({tag, ".x"}, 32'(x), 32'd0);
    check({tag, ".valid"}, 32'(valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".hits"}, 32'(hits), 32'(exp_hits));
    check({tag, ".hits_sat"}, 32'(hits_s), 32'(exp_hits != 4'd0));
  endtask

  // exp_bits: expected stream left-aligned; hseq: expected hits per bit cycle, one nibble each
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] n,
                           input int nb, input logic [7:0] exp_bits,
                           input logic [31:0] hseq, input bit hold);
    logic [3:0] hv;
    hv = '0;
    data  = d;
    len   = n;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      hv = hseq[31-4*i -: 4];
      check({tag, ".x"}, 32'(x), 32'(exp_bits[7-i]));
      check({tag, ".x_sat"}, 32'(x_s), 32'(exp_bits[7-i]));
      check({tag, ".valid"}, 32'(valid), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".hits"}, 32'(hits), 32'(hv));
      check({tag, ".hits_sat"}, 32'(hits_s), 32'(hv != 4'd0));
      step();
    end
    check({tag, ".done_pulse"}, 32'(done), 32'd1);
    check({tag, ".done_busy"}, 32'(busy), 32'd1);
    check({tag, ".done_valid"}, 32'(valid), 32'd0);
    check({tag, ".done_x"}, 32'(x), 32'd0);
    check({tag, ".done_hits"}, 32'(hits), 32'(hv));
    $display("frame %s: data=%02h len=%0d bits=%0d hits=%0d hits_sat=%0d", tag, d, n, nb, hits, hits_s);
    step();
    check({tag, ".idle_done"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_hits"}, 32'(hits), 32'(hv));
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check_quiet("reset", 4'd0);
    step();
    check_quiet("idle", 4'd0);
    $display("reset: x=%0b valid=%0b busy=%0b done=%0b hits=%0d", x, valid, busy, done, hits);

    // Full 8-bit frame with three overlapping hits
    run_frame("b5_len8", 8'hB5, 4'd8, 8, 8'b10110101, 32'h00111223, 1'b0);

    // Short frame, then len=0 ignored, then clamped len
    run_frame("05_len3", 8'h05, 4'd3, 3, 8'b10100000, 32'h00100000, 1'b0);
    data  = 8'hFF;
    len   = 4'd0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("len0", 4'd1);
    end
    start = 1'b0;
    $display("len0: start ignored, hits=%0d", hits);
    run_frame("a5_len12", 8'hA5, 4'd12, 8, 8'hA5, 32'h00111112, 1'b0);

    // start held high: next frame accepted two cycles after done
    run_frame("ff_hold", 8'hFF, 4'd4, 4, 8'hF0, 32'h00000000, 1'b1);
    step();
    check("hold.next_x", 32'(x), 32'd1);
    check("hold.next_valid", 32'(valid), 32'd1);
    check("hold.next_hits", 32'(hits), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("hold.next_done", 32'(done), 32'd1);
    step();
    $display("hold: back-to-back frame completed, hits=%0d", hits);

    // Reset in the middle of a frame
    data  = 8'hB5;
    len   = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("midrst.pre_hits", 32'(hits), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("midrst", 4'd0);
    step();
    check_quiet("midrst_nodone", 4'd0);
    $display("midrst: frame aborted, outputs cleared");
    run_frame("after_rst", 8'h05, 4'd3, 3, 8'b10100000, 32'h00100000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
